// File: rtl/bz_tone_recorder.sv
// rtl/bz_tone_recorder.sv - square-wave note recorder producing (period, beat) records
//
// Purpose:
//   Watches a square-wave tone, measures the period and the length of each
//   note, and queues one (period, beat) record per note in a small FIFO.
//   Software uses the records to verify or replay melodies played on the buzzer.
//
// Ports:
//   i_clk          system clock
//   i_rstn         asynchronous active-low reset
//   i_en           recorder enable; low aborts any note and returns to IDLE (FIFO kept)
//   i_tone_in      asynchronous square-wave input
//   o_rec_valid    FIFO head record available
//   i_rec_ready    head is popped when o_rec_valid & i_rec_ready
//   o_rec_period   head record: note period in clk cycles
//   o_rec_beat     head record: note length in beat units, saturated at 15
//   o_busy         recorder is inside a note (state != IDLE)
//   o_overflow     sticky: a record was dropped because the FIFO was full
//   i_ovf_clr      synchronous clear of o_overflow (a drop in the same cycle wins)

module bz_tone_recorder #(
   parameter int PERIOD_W    = 20,
   parameter int BEAT_UNIT   = 12_500_000,
   parameter int SILENCE_CYC = 1_000_000,
   parameter int TOL         = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_en,
   input  logic                i_tone_in,
   output logic                o_rec_valid,
   input  logic                i_rec_ready,
   output logic [PERIOD_W-1:0] o_rec_period,
   output logic [3:0]          o_rec_beat,
   output logic                o_busy,
   output logic                o_overflow,
   input  logic                i_ovf_clr
);

   localparam int PRESC_W = $clog2(BEAT_UNIT + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);

   localparam logic [PERIOD_W-1:0] LP_SIL        = PERIOD_W'(SILENCE_CYC);
   localparam logic [PERIOD_W:0]   LP_TOL        = (PERIOD_W+1)'(TOL);
   localparam logic [PRESC_W-1:0]  LP_PRESC_LAST = PRESC_W'(BEAT_UNIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchroniser and rising-edge detect
   // ------------------------------------------------------------------
   logic [2:0] r_sync;
   logic       w_rise;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[1:0], i_tone_in};
      end
   end

   assign w_rise = r_sync[1] & ~r_sync[2];

   // ------------------------------------------------------------------
   // Period counter: value at a rise equals cycles since the previous rise
   // ------------------------------------------------------------------
   logic [PERIOD_W-1:0] r_per_cnt;
   logic                w_silence;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_per_cnt <= '0;
      end else if (!i_en) begin
         r_per_cnt <= '0;
      end else if (w_rise) begin
         r_per_cnt <= PERIOD_W'(1);
      end else if (r_per_cnt != '1) begin
         r_per_cnt <= r_per_cnt + PERIOD_W'(1);
      end
   end

   // A rise landing on the very cycle the limit is reached still counts as a rise.
   assign w_silence = (r_per_cnt == LP_SIL) && !w_rise;

   // ------------------------------------------------------------------
   // Lock comparison, unsigned with one extra bit so nothing wraps
   // ------------------------------------------------------------------
   logic [PERIOD_W-1:0] r_lock;
   logic [PERIOD_W:0]   w_diff;
   logic                w_match;

   assign w_diff  = (r_per_cnt >= r_lock) ? ({1'b0, r_per_cnt} - {1'b0, r_lock})
                                          : ({1'b0, r_lock} - {1'b0, r_per_cnt});
   assign w_match = (w_diff <= LP_TOL);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_start;
   logic        w_lock_load;
   logic        w_close;
   logic [3:0]  w_close_beat;
   logic [3:0]  r_beat;
   logic [3:0]  r_beat_snap;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_lock_load  = 1'b0;
      w_close      = 1'b0;
      w_close_beat = r_beat_snap;
      case (r_state)
         ST_IDLE: begin
            if (i_en && w_rise) begin
               w_state_nxt = ST_ACQ;
               w_start     = 1'b1;
            end
         end
         ST_ACQ: begin
            if (w_rise) begin
               w_state_nxt = ST_TRACK;
               w_lock_load = 1'b1;
            end else if (w_silence) begin
               // A lone edge is a glitch: no record.
               w_state_nxt = ST_IDLE;
            end
         end
         ST_TRACK: begin
            if (w_rise) begin
               if (!w_match) begin
                  // Pitch change: close the old note at this rise and open
                  // a new, already-locked note on the same edge.
                  w_close      = 1'b1;
                  w_close_beat = r_beat;
                  w_start      = 1'b1;
                  w_lock_load  = 1'b1;
               end
            end else if (w_silence) begin
               w_close     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (!i_en) begin
         w_state_nxt = ST_IDLE;
      end
   end

   assign o_busy = (r_state != ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_lock <= '0;
      end else if (w_lock_load) begin
         r_lock <= r_per_cnt;
      end
   end

   // ------------------------------------------------------------------
   // Beat timer. The note-start cycle is cycle 0 of the note, so the
   // timer is zeroed combinationally in that cycle and advanced from
   // there; at a rise k cycles into a note r_beat equals floor(k/BEAT_UNIT).
   // ------------------------------------------------------------------
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] w_presc_cur;
   logic [3:0]         w_beat_cur;

   assign w_presc_cur = w_start ? '0 : r_presc;
   assign w_beat_cur  = w_start ? 4'd0 : r_beat;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_presc <= '0;
         r_beat  <= 4'd0;
      end else if (!i_en) begin
         r_presc <= '0;
         r_beat  <= 4'd0;
      end else if (w_presc_cur == LP_PRESC_LAST) begin
         r_presc <= '0;
         r_beat  <= (w_beat_cur != 4'd15) ? (w_beat_cur + 4'd1) : w_beat_cur;
      end else begin
         r_presc <= w_presc_cur + PRESC_W'(1);
         r_beat  <= w_beat_cur;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_beat_snap <= 4'd0;
      end else if (!i_en) begin
         r_beat_snap <= 4'd0;
      end else if (w_rise) begin
         r_beat_snap <= w_beat_cur;
      end
   end

   // ------------------------------------------------------------------
   // Close -> push stage. Not gated by i_en so a close decided in the
   // cycle enable falls still reaches the FIFO.
   // ------------------------------------------------------------------
   logic                r_push;
   logic [PERIOD_W-1:0] r_push_period;
   logic [3:0]          r_push_beat;
   logic                w_push;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_push        <= 1'b0;
         r_push_period <= '0;
         r_push_beat   <= 4'd0;
      end else begin
         r_push        <= w_close;
         r_push_period <= r_lock;
         r_push_beat   <= w_close_beat;
      end
   end

   // Zero-beat notes are dropped silently and never flag overflow.
   assign w_push = r_push && (r_push_beat != 4'd0);

   // ------------------------------------------------------------------
   // Record FIFO, first-word fall-through
   // ------------------------------------------------------------------
   logic [PERIOD_W-1:0] r_mem_period [FIFO_DEPTH];
   logic [3:0]          r_mem_beat   [FIFO_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;
   logic                w_drop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && i_rec_ready;
   // When full, a simultaneous pop frees the slot being written.
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_period[i] <= '0;
            r_mem_beat[i]   <= 4'd0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) begin
            r_mem_period[r_wr_ptr[AW-1:0]] <= r_push_period;
            r_mem_beat[r_wr_ptr[AW-1:0]]   <= r_push_beat;
            r_wr_ptr                       <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign o_rec_valid  = !w_empty;
   assign o_rec_period = r_mem_period[r_rd_ptr[AW-1:0]];
   assign o_rec_beat   = r_mem_beat[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_overflow <= 1'b0;
      end else if (w_drop) begin
         o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
         o_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bz_tone_recorder.sv
// tb/tb_bz_tone_recorder.sv - self-checking bench for bz_tone_recorder

module tb_bz_tone_recorder;

   localparam int PW   = 20;
   localparam int BU   = 100;
   localparam int SIL  = 64;
   localparam int TOLV = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic          tone;
   logic          rec_valid;
   logic          rec_ready;
   logic [PW-1:0] rec_period;
   logic [3:0]    rec_beat;
   logic          busy;
   logic          overflow;
   logic          ovf_clr;

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;

   int            per_q[$];
   int            rise_q[$];
   logic [23:0]   exp_q[$];
   logic [23:0]   got_q[$];

   bz_tone_recorder #(
      .PERIOD_W    (PW),
      .BEAT_UNIT   (BU),
      .SILENCE_CYC (SIL),
      .TOL         (TOLV),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_en         (en),
      .i_tone_in    (tone),
      .o_rec_valid  (rec_valid),
      .i_rec_ready  (rec_ready),
      .o_rec_period (rec_period),
      .o_rec_beat   (rec_beat),
      .o_busy       (busy),
      .o_overflow   (overflow),
      .i_ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn && rec_valid && rec_ready) got_q.push_back({rec_period, rec_beat});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Positive entry = one tone period starting with a rising edge; negative = low cycles.
   task automatic play(input bit trail);
      foreach (per_q[i]) begin
         int p;
         p = per_q[i];
         if (p < 0) begin
            tone = 1'b0;
            repeat (-p) tick();
         end else begin
            tone = 1'b1;
            rise_q.push_back(cyc);
            repeat (p / 2) tick();
            tone = 1'b0;
            repeat (p - p / 2) tick();
         end
      end
      per_q.delete();
      if (trail) repeat (100) tick();
   endtask

   task automatic add_note(input int p, input int n);
      repeat (n) per_q.push_back(p);
   endtask

   function automatic void emit(input int per, input int off);
      int b;
      b = off / BU;
      if (b > 15) b = 15;
      if (b != 0) exp_q.push_back({per[19:0], b[3:0]});
   endfunction

   // Note segmentation from the recorded rise times.
   task automatic model();
      int start, lock, last, gap, r, dd;
      bit in_note, acq;
      exp_q.delete();
      in_note = 0; acq = 0; start = 0; lock = 0; last = 0;
      foreach (rise_q[i]) begin
         r = rise_q[i];
         if (in_note && (r - last) > SIL) begin
            if (acq) emit(lock, last - start);
            in_note = 0;
         end
         if (!in_note) begin
            in_note = 1; acq = 0; start = r;
         end else begin
            gap = r - last;
            dd  = (gap > lock) ? gap - lock : lock - gap;
            if (!acq) begin
               acq = 1; lock = gap;
            end else if (dd > TOLV) begin
               emit(lock, r - start);
               start = r; lock = gap;
            end
         end
         last = r;
      end
      if (in_note && acq) emit(lock, last - start);
   endtask

   task automatic scen_begin();
      rise_q.delete();
      got_q.delete();
   endtask

   task automatic scen_check(input string tag);
      model();
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_rec"}, (i < got_q.size()) ? {8'h0, got_q[i]} : 32'hFFFF_FFFF,
               {8'h0, exp_q[i]});
      end
   endtask

   initial begin
      int last_rise;
      rstn = 1'b0; en = 1'b0; tone = 1'b0; rec_ready = 1'b1; ovf_clr = 1'b0;
      repeat (3) tick();
      check("rst_valid", rec_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_period", rec_period, 0);
      check("rst_beat", rec_beat, 0);
      rstn = 1'b1;
      en   = 1'b1;
      repeat (5) tick();

      // 1: 30 periods of 20, then silence
      scen_begin();
      add_note(20, 30);
      play(0);
      last_rise = rise_q[$];
      while (cyc < last_rise + 60) tick();
      check("t1_busy_hold", busy, 1'b1);
      while (cyc < last_rise + 70) tick();
      check("t1_busy_drop", busy, 1'b0);
      repeat (40) tick();
      scen_check("t1");
      check("t1_const", (got_q.size() > 0) ? {8'h0, got_q[0]} : 32'hFFFF_FFFF,
            {8'h0, 20'd20, 4'd5});

      // 2: pitch change 20 -> 40
      scen_begin();
      add_note(20, 20);
      add_note(40, 10);
      play(1);
      scen_check("t2");

      // 3: jitter absorbed by tolerance
      scen_begin();
      for (int i = 0; i < 5; i++) begin
         per_q.push_back(20); per_q.push_back(21); per_q.push_back(19);
      end
      play(1);
      scen_check("t3");
      check("t3_single", got_q.size(), 1);

      // 4: glitch pulse, then zero-beat note
      scen_begin();
      add_note(30, 1);
      per_q.push_back(-100);
      add_note(20, 3);
      play(1);
      scen_check("t4");
      check("t4_none", got_q.size(), 0);
      check("t4_ovf", overflow, 1'b0);

      // random notes, tempo changes, jitter and gaps
      for (int round = 0; round < 3; round++) begin
         scen_begin();
         for (int s = 0; s < 5; s++) begin
            int base, n;
            bit jit;
            base = $urandom_range(10, 50);
            n    = $urandom_range(1, 12);
            jit  = $urandom_range(0, 1);
            for (int k = 0; k < n; k++) begin
               per_q.push_back(jit ? base + $urandom_range(0, 4) - 2 : base);
            end
            if ($urandom_range(0, 2) == 0) per_q.push_back(-100);
         end
         play(1);
         scen_check("rand");
      end

      // 5: FIFO fill with no consumer, overflow, ordered drain, clear
      scen_begin();
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         add_note(22 + 4 * i, 12);
         per_q.push_back(-100);
      end
      play(1);
      model();
      check("t5_valid", rec_valid, 1'b1);
      check("t5_ovf", overflow, 1'b1);
      check("t5_head", {rec_period, rec_beat}, (exp_q.size() > 0) ? exp_q[0] : 24'hFFFFFF);
      rec_ready = 1'b1;
      repeat (10) tick();
      check("t5_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t5_rec", (i < got_q.size()) ? {8'h0, got_q[i]} : 32'hFFFF_FFFF,
               (i < exp_q.size()) ? {8'h0, exp_q[i]} : 32'hEEEE_EEEE);
      end
      check("t5_ovf_sticky", overflow, 1'b1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t5_ovf_clr", overflow, 1'b0);

      // 6: enable drop and reset mid-note
      scen_begin();
      rec_ready = 1'b0;
      add_note(25, 10);
      play(1);
      model();
      add_note(20, 8);
      play(0);
      en = 1'b0;
      tick();
      check("t6_busy_en", busy, 1'b0);
      repeat (100) tick();
      check("t6_kept_valid", rec_valid, 1'b1);
      check("t6_kept_head", {rec_period, rec_beat}, (exp_q.size() > 0) ? exp_q[0] : 24'hFFFFFF);
      en = 1'b1;
      tick();
      add_note(20, 8);
      play(0);
      check("t6_busy_pre", busy, 1'b1);
      rstn = 1'b0;
      tick();
      check("t6_rst_valid", rec_valid, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      rstn = 1'b1;
      repeat (100) tick();
      rec_ready = 1'b1;
      repeat (10) tick();
      check("t6_none", got_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
